// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback scheduler:
// datapath geometry, writeback request record and client indices.
package rf_pkg;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 3;
  localparam int NREG   = 2 ** ADDR_W;

  localparam logic CLIENT_ALU = 1'b0;
  localparam logic CLIENT_MEM = 1'b1;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins; on contention
// the client named by rr_ptr wins and the pointer moves to the loser, so
// the loser is guaranteed the next contested grant.
module rf_rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic rr_ptr;
  logic contest;

  // Grant decode: a grant is only ever given to a valid requester.
  always_comb begin
    contest  = valid[0] && valid[1];
    grant[0] = valid[0] && (!valid[1] || (rr_ptr == CLIENT_ALU));
    grant[1] = valid[1] && (!valid[0] || (rr_ptr == CLIENT_MEM));
  end

  // Pointer moves to the losing client on contested cycles only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= CLIENT_ALU;
    end else if (contest) begin
      rr_ptr <= ~rr_ptr;
    end
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Writeback scheduler for the 8x24 register file: arbitrates the single
// write port between the ALU (client 0) and load (client 1) paths, drives
// the port through one register stage, and keeps the pending-write
// scoreboard used for hazard stalls.
// Optional macro RF_WB_SCHED_STATS_EN adds saturating 16-bit counters for
// contested cycles and discarded R0 writes.
module rf_wb_scheduler
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wb0_valid,
  input  logic [ADDR_W-1:0] wb0_rd,
  input  logic [DATA_W-1:0] wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [ADDR_W-1:0] wb1_rd,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb1_ready,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              iss_ready,
  input  logic [ADDR_W-1:0] qa_addr,
  input  logic [ADDR_W-1:0] qb_addr,
  output logic              qa_busy,
  output logic              qb_busy,
  output logic              rf_en_write,
  output logic [ADDR_W-1:0] rf_rw,
  output logic [DATA_W-1:0] rf_busw
`ifdef RF_WB_SCHED_STATS_EN
  ,
  output logic [15:0]       stat_conflicts,
  output logic [15:0]       stat_r0_drops
`endif
);

  localparam logic [NREG-1:0] R0_MASK = {{(NREG-1){1'b1}}, 1'b0};

  wb_req_t         req0, req1, sel;
  logic [1:0]      grant;
  logic            accept;
  logic [NREG-1:0] busy, set_mask, clr_mask;

  rf_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid ({wb1_valid, wb0_valid}),
    .grant (grant)
  );

  // Request mux: with no grant sel is client 0's idle request, so sel.valid
  // is exactly "some request was accepted".
  always_comb begin
    req0      = '{valid: wb0_valid, rd: wb0_rd, data: wb0_data};
    req1      = '{valid: wb1_valid, rd: wb1_rd, data: wb1_data};
    sel       = grant[1] ? req1 : req0;
    accept    = sel.valid;
    wb0_ready = grant[0];
    wb1_ready = grant[1];
  end

  // Output stage: one write per clock; address/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_en_write <= 1'b0;
      rf_rw       <= '0;
      rf_busw     <= '0;
    end else begin
      rf_en_write <= accept && (sel.rd != '0);
      if (accept) begin
        rf_rw   <= sel.rd;
        rf_busw <= sel.data;
      end
    end
  end

  // Scoreboard set/clear masks; clear tracks the register actually written.
  always_comb begin
    set_mask  = '0;
    clr_mask  = '0;
    iss_ready = !busy[iss_rd] || (iss_rd == '0);
    if (iss_valid && iss_ready && (iss_rd != '0)) set_mask[iss_rd] = 1'b1;
    if (rf_en_write) clr_mask[rf_rw] = 1'b1;
    qa_busy = busy[qa_addr];
    qb_busy = busy[qb_addr];
  end

  // Set is applied after clear so a same-edge reissue keeps the register busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= ((busy & ~clr_mask) | set_mask) & R0_MASK;
    end
  end

`ifdef RF_WB_SCHED_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_conflicts <= '0;
      stat_r0_drops  <= '0;
    end else begin
      if (wb0_valid && wb1_valid && (stat_conflicts != 16'hFFFF))
        stat_conflicts <= stat_conflicts + 16'd1;
      if (accept && (sel.rd == '0) && (stat_r0_drops != 16'hFFFF))
        stat_r0_drops <= stat_r0_drops + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler with a small register-file model.
module tb_rf_wb_scheduler;

  logic        clk, rst;
  logic        wb0_valid, wb1_valid, iss_valid;
  logic [2:0]  wb0_rd, wb1_rd, iss_rd, qa_addr, qb_addr;
  logic [23:0] wb0_data, wb1_data;
  logic        wb0_ready, wb1_ready, iss_ready, qa_busy, qb_busy;
  logic        rf_en_write;
  logic [2:0]  rf_rw;
  logic [23:0] rf_busw;
`ifdef RF_WB_SCHED_STATS_EN
  logic [15:0] stat_conflicts, stat_r0_drops;
`endif

  int checks = 0;
  int errors = 0;
  logic [23:0] mem [8];

  rf_wb_scheduler dut (
    .clk(clk), .rst(rst),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .qa_addr(qa_addr), .qb_addr(qb_addr), .qa_busy(qa_busy), .qb_busy(qb_busy),
    .rf_en_write(rf_en_write), .rf_rw(rf_rw), .rf_busw(rf_busw)
`ifdef RF_WB_SCHED_STATS_EN
    , .stat_conflicts(stat_conflicts), .stat_r0_drops(stat_r0_drops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: commits at the edge ending the enable cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (rf_en_write) begin
      mem[rf_rw] <= rf_busw;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    qa_addr = 3'd3; qb_addr = 3'd5; iss_rd = 3'd5;
    #1;
    checks++; if (rf_en_write !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", rf_en_write); end
    checks++; if (rf_rw !== 3'd0) begin errors++; $display("FAIL reset_rw got %0d exp 0", rf_rw); end
    checks++; if (rf_busw !== 24'd0) begin errors++; $display("FAIL reset_busw got %h exp 0", rf_busw); end
    checks++; if ({wb0_ready, wb1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {wb0_ready, wb1_ready}); end
    checks++; if ({qa_busy, qb_busy, iss_ready} !== 3'b001) begin errors++; $display("FAIL reset_busy got %b exp 001", {qa_busy, qb_busy, iss_ready}); end
  endtask

  task automatic test_single;
    wb0_valid = 1'b1; wb0_rd = 3'd5; wb0_data = 24'h123456;
    #1;
    checks++; if (wb0_ready !== 1'b1 || wb1_ready !== 1'b0) begin errors++; $display("FAIL single_ready got %b%b exp 10", wb0_ready, wb1_ready); end
    tick;
    wb0_valid = 1'b0;
    checks++; if ({rf_en_write, rf_rw, rf_busw} !== {1'b1, 3'd5, 24'h123456}) begin
      errors++; $display("FAIL single_write got en=%b rw=%0d busw=%h exp en=1 rw=5 busw=123456", rf_en_write, rf_rw, rf_busw); end
    tick;
    checks++; if ({rf_en_write, rf_rw, rf_busw} !== {1'b0, 3'd5, 24'h123456}) begin
      errors++; $display("FAIL single_idle got en=%b rw=%0d busw=%h exp en=0 rw=5 busw=123456", rf_en_write, rf_rw, rf_busw); end
    checks++; if (mem[5] !== 24'h123456) begin errors++; $display("FAIL single_rf got %h exp 123456", mem[5]); end
  endtask

  task automatic test_contention;
    wb0_valid = 1'b1; wb0_rd = 3'd1; wb0_data = 24'h111111;
    wb1_valid = 1'b1; wb1_rd = 3'd2; wb1_data = 24'h222222;
    #1;
    checks++; if ({wb0_ready, wb1_ready} !== 2'b10) begin errors++; $display("FAIL cont_grant1 got %b%b exp 10", wb0_ready, wb1_ready); end
    tick;
    wb0_data = 24'h333333;
    #1;
    checks++; if ({wb0_ready, wb1_ready} !== 2'b01) begin errors++; $display("FAIL cont_grant2 got %b%b exp 01", wb0_ready, wb1_ready); end
    checks++; if ({rf_en_write, rf_rw, rf_busw} !== {1'b1, 3'd1, 24'h111111}) begin
      errors++; $display("FAIL cont_write1 got en=%b rw=%0d busw=%h exp 1/1/111111", rf_en_write, rf_rw, rf_busw); end
    tick;
    wb1_data = 24'h444444;
    #1;
    checks++; if ({wb0_ready, wb1_ready} !== 2'b10) begin errors++; $display("FAIL cont_grant3 got %b%b exp 10", wb0_ready, wb1_ready); end
    checks++; if ({rf_en_write, rf_rw, rf_busw} !== {1'b1, 3'd2, 24'h222222}) begin
      errors++; $display("FAIL cont_write2 got en=%b rw=%0d busw=%h exp 1/2/222222", rf_en_write, rf_rw, rf_busw); end
    tick;
    wb0_valid = 1'b0;
    #1;
    checks++; if ({wb0_ready, wb1_ready} !== 2'b01) begin errors++; $display("FAIL cont_alone got %b%b exp 01", wb0_ready, wb1_ready); end
    checks++; if ({rf_en_write, rf_rw, rf_busw} !== {1'b1, 3'd1, 24'h333333}) begin
      errors++; $display("FAIL cont_write3 got en=%b rw=%0d busw=%h exp 1/1/333333", rf_en_write, rf_rw, rf_busw); end
    tick;
    wb1_valid = 1'b0;
    checks++; if ({rf_en_write, rf_rw, rf_busw} !== {1'b1, 3'd2, 24'h444444}) begin
      errors++; $display("FAIL cont_write4 got en=%b rw=%0d busw=%h exp 1/2/444444", rf_en_write, rf_rw, rf_busw); end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [23:0] d [3];
    d[0] = 24'h0A0A0A; d[1] = 24'h0B0B0B; d[2] = 24'h0C0C0C;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        wb0_valid = 1'b1; wb0_rd = 3'(5 + i); wb0_data = d[i];
      end else begin
        wb0_valid = 1'b0;
      end
      #1;
      if (i > 0) begin
        checks++; if ({rf_en_write, rf_rw, rf_busw} !== {1'b1, 3'(4 + i), d[i-1]}) begin
          errors++; $display("FAIL b2b_write%0d got en=%b rw=%0d busw=%h exp 1/%0d/%h", i, rf_en_write, rf_rw, rf_busw, 4 + i, d[i-1]); end
      end
      tick;
    end
    checks++; if ({mem[5], mem[6], mem[7]} !== {d[0], d[1], d[2]}) begin
      errors++; $display("FAIL b2b_rf got %h %h %h exp %h %h %h", mem[5], mem[6], mem[7], d[0], d[1], d[2]); end
  endtask

  task automatic test_reset_mid;
    iss_valid = 1'b1; iss_rd = 3'd3; qa_addr = 3'd3;
    tick;
    iss_valid = 1'b0;
    checks++; if (qa_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_set got %b exp 1", qa_busy); end
    wb0_valid = 1'b1; wb0_rd = 3'd3; wb0_data = 24'h00ABCD;
    tick;
    wb0_valid = 1'b0;
    checks++; if (rf_en_write !== 1'b1) begin errors++; $display("FAIL rstmid_pre got en=%b exp 1", rf_en_write); end
    rst = 1'b1;
    #1;
    checks++; if ({rf_en_write, qa_busy} !== 2'b00) begin errors++; $display("FAIL rstmid_drop got en=%b busy=%b exp 0 0", rf_en_write, qa_busy); end
    tick;
    rst = 1'b0;
    tick;
    checks++; if (mem[3] === 24'h00ABCD) begin errors++; $display("FAIL rstmid_rf got %h exp not 00abcd", mem[3]); end
    wb0_valid = 1'b1; wb0_rd = 3'd1; wb0_data = 24'h000001;
    wb1_valid = 1'b1; wb1_rd = 3'd2; wb1_data = 24'h000002;
    #1;
    checks++; if ({wb0_ready, wb1_ready} !== 2'b10) begin errors++; $display("FAIL rstmid_ptr got %b%b exp 10", wb0_ready, wb1_ready); end
    tick;
    wb0_valid = 1'b0;
    tick;
    wb1_valid = 1'b0;
    tick;
  endtask

  task automatic test_r0;
    wb1_valid = 1'b1; wb1_rd = 3'd0; wb1_data = 24'hFFFFFF;
    #1;
    checks++; if (wb1_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %b exp 1", wb1_ready); end
    tick;
    wb1_valid = 1'b0;
    checks++; if (rf_en_write !== 1'b0) begin errors++; $display("FAIL r0_en got %b exp 0", rf_en_write); end
    tick;
    checks++; if (mem[0] !== 24'd0) begin errors++; $display("FAIL r0_rf got %h exp 0", mem[0]); end
`ifdef RF_WB_SCHED_STATS_EN
    checks++; if (stat_r0_drops !== 16'd1) begin errors++; $display("FAIL r0_stat got %0d exp 1", stat_r0_drops); end
    checks++; if (stat_conflicts !== 16'd1) begin errors++; $display("FAIL conflict_stat got %0d exp 1", stat_conflicts); end
`endif
  endtask

  task automatic test_scoreboard;
    iss_valid = 1'b1; iss_rd = 3'd4; qa_addr = 3'd4; qb_addr = 3'd4;
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sb_iss_free got %b exp 1", iss_ready); end
    tick;
    iss_valid = 1'b0;
    #1;
    checks++; if ({qa_busy, qb_busy, iss_ready} !== 3'b110) begin errors++; $display("FAIL sb_set got %b exp 110", {qa_busy, qb_busy, iss_ready}); end
    wb0_valid = 1'b1; wb0_rd = 3'd4; wb0_data = 24'h040404;
    tick;
    wb0_valid = 1'b0;
    checks++; if ({rf_en_write, qa_busy} !== 2'b11) begin errors++; $display("FAIL sb_hold got en=%b busy=%b exp 1 1", rf_en_write, qa_busy); end
    tick;
    checks++; if (qa_busy !== 1'b0) begin errors++; $display("FAIL sb_clear got %b exp 0", qa_busy); end
    // Write to a non-busy R4, then reissue R4 during the enable cycle.
    wb0_valid = 1'b1; wb0_data = 24'h050505;
    tick;
    wb0_valid = 1'b0; iss_valid = 1'b1;
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sb_reiss_ready got %b exp 1", iss_ready); end
    tick;
    iss_valid = 1'b0;
    checks++; if (qa_busy !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %b exp 1", qa_busy); end
    checks++; if (mem[4] !== 24'h050505) begin errors++; $display("FAIL sb_nonbusy_write got %h exp 050505", mem[4]); end
    iss_valid = 1'b1; iss_rd = 3'd0; qb_addr = 3'd0;
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sb_r0_ready got %b exp 1", iss_ready); end
    tick;
    iss_valid = 1'b0;
    checks++; if (qb_busy !== 1'b0) begin errors++; $display("FAIL sb_r0_busy got %b exp 0", qb_busy); end
    wb0_valid = 1'b1; wb0_rd = 3'd4;
    tick;
    wb0_valid = 1'b0;
    tick;
    checks++; if (qa_busy !== 1'b0) begin errors++; $display("FAIL sb_final_clear got %b exp 0", qa_busy); end
  endtask

`ifdef RF_WB_SCHED_STATS_EN
  task automatic test_stats_sat;
    force dut.stat_conflicts = 16'hFFFE;
    #1;
    release dut.stat_conflicts;
    wb0_valid = 1'b1; wb0_rd = 3'd6; wb1_valid = 1'b1; wb1_rd = 3'd7;
    tick;
    checks++; if (stat_conflicts !== 16'hFFFF) begin errors++; $display("FAIL stat_sat1 got %h exp ffff", stat_conflicts); end
    tick;
    checks++; if (stat_conflicts !== 16'hFFFF) begin errors++; $display("FAIL stat_sat2 got %h exp ffff", stat_conflicts); end
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    tick;
  endtask
`endif

  initial begin
    rst = 1'b1;
    wb0_valid = 1'b0; wb0_rd = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_rd = '0; wb1_data = '0;
    iss_valid = 1'b0; iss_rd = '0; qa_addr = '0; qb_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset;
    test_single;
    test_contention;
    test_back_to_back;
    test_reset_mid;
    test_r0;
    test_scoreboard;
`ifdef RF_WB_SCHED_STATS_EN
    test_stats_sat;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Shares the single write port (Rw/BusW/enWrite) of the 8x24-bit register file between two writeback requesters: client 0 (ALU result) and client 1 (memory load).
- Keeps a per-register pending-write scoreboard, set at instruction issue and cleared at writeback.
- The control unit uses the scoreboard to stall RAW/WAW hazards.
- Sits between the multicycle control/datapath and register_file; drives the register file write port through one output register stage.

Parameters:
- DATA_W, 24, register/data width
- ADDR_W, 3, register address width
- NREG, 8, number of registers (2**ADDR_W)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- wb0_valid  input  1  client 0 write request
- wb0_rd  input  ADDR_W  client 0 destination register
- wb0_data  input  DATA_W  client 0 write data
- wb0_ready  output  1  client 0 request accepted this cycle
- wb1_valid, wb1_rd, wb1_data, wb1_ready  same as client 0, for client 1
- iss_valid  input  1  issue of an instruction with a destination register
- iss_rd  input  ADDR_W  destination register of the issuing instruction
- iss_ready  output  1  issue allowed (no WAW on iss_rd)
- qa_addr, qb_addr  input  ADDR_W  source register hazard queries
- qa_busy, qb_busy  output  1  queried register has a pending write
- rf_en_write  output  1  to register_file enWrite
- rf_rw  output  ADDR_W  to register_file Rw
- rf_busw  output  DATA_W  to register_file BusW

Behaviour:
- Reset (async, rst=1):
  - busy[NREG-1:0] = 0; rr_ptr = 0 (client 0 has priority first).
  - rf_en_write = 0, rf_rw = 0, rf_busw = 0.
  - Stats counters (if present) = 0.
  - Reset asserted mid-operation drops any registered write; no partial write reaches the register file after rst rises.
- Arbitration (combinational, per cycle):
  - Only one valid: that client gets ready=1.
  - Both valid: client rr_ptr wins; the other gets ready=0 and must hold valid, rd and data stable.
  - rr_ptr updates at the edge of a contested grant to the loser's index. Uncontested grants leave rr_ptr unchanged.
  - A ready is never asserted without the matching valid.
- Write stage:
  - An accepted request at edge N drives rf_rw/rf_busw and rf_en_write=1 during cycle N+1 (latency 1). The register file commits the data at edge N+1.
  - The output stage drains every cycle, so a fresh accept is possible every cycle; throughput is 1 write per clock.
  - No accept at edge N: rf_en_write=0 in cycle N+1; rf_rw/rf_busw hold their previous values.
  - Request with rd=0: accepted normally, but rf_en_write stays 0. R0 is never written.
- Scoreboard:
  - iss_ready = !busy[iss_rd] || iss_rd==0, combinational.
  - Issue fire (iss_valid && iss_ready) with rd!=0 sets busy[rd] at the edge.
  - busy[rd] clears at the edge ending the rf_en_write cycle for that rd (edge N+1).
  - Simultaneous set and clear of the same register at the same edge: set wins.
  - Writeback to a non-busy register: the write is still performed; busy is unchanged.
  - qa_busy = busy[qa_addr], qb_busy = busy[qb_addr], combinational. busy[0] is constant 0.
  - The query does not see the clear in the same cycle as rf_en_write. The consumer reads one cycle later, matching the register file's registered read.

Optional Feature:
- Macro: RF_WB_SCHED_STATS_EN.
- Defined:
  - Adds outputs stat_conflicts (16-bit) and stat_r0_drops (16-bit).
  - stat_conflicts increments on every cycle with both valids high.
  - stat_r0_drops increments on every accepted rd=0 request.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package rf_pkg:
  - DATA_W/ADDR_W/NREG constants.
  - wb_req_t typedef (valid, rd, data).
  - CLIENT_ALU=0, CLIENT_MEM=1 constants.
- One natural sub-module: rf_rr_arb2, the two-way round-robin arbiter (valids in, grants out, rr_ptr state). Scoreboard and write stage stay in the top.

Test Plan:
- Reset mid-write: accept wb0 rd=3 data=24'h00ABCD, assert rst before edge N+1 -> rf_en_write=0 immediately, busy=0, rr_ptr=0 after release.
- Single client: wb0_valid rd=5 data=24'h123456 at edge N -> wb0_ready=1; cycle N+1 rf_en_write=1, rf_rw=5, rf_busw=24'h123456; RF read of R5 returns 24'h123456.
- Contention: both valid 3 consecutive cycles, rd0=1/rd1=2 -> grants 0,1,0; writes appear in that order one per cycle; loser holds data unchanged.
- R0 discard: wb1 rd=0 data=24'hFFFFFF -> wb1_ready=1, rf_en_write stays 0; R0 reads 0; stat_r0_drops=1 with RF_WB_SCHED_STATS_EN.
- Scoreboard: issue rd=4 -> qa_busy(4)=1, iss_ready for rd=4 =0. Writeback rd=4 -> busy clears after edge N+1. Same-edge reissue of rd=4 with that clear -> busy stays 1.
- Stats saturation: force stat_conflicts to 16'hFFFE, two contested cycles -> value 16'hFFFF and holds.
